param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter ASIZE, default 4, address width; depth DEPTH = 2**ASIZE entries (ASIZE >= 1).
REQ-003 SHALL have parameter AF_LEVEL, default 14, almost-full threshold in entries (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in entries (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port wdata  input  DSIZE  write data.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port rinc  input  1  read request (pop head).
REQ-010 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-011 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-012 SHALL have port rdata  output  DSIZE  head-of-queue data (first-word fall-through).
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-017 SHALL have port count  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-018 SHALL have port overflow  output  1  sticky: write attempted and rejected.
REQ-019 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-020 Write and read pointers SHALL be ASIZE+1 bits; the low ASIZE bits address memory and the MSB is the wrap bit; both SHALL wrap modulo 2**(ASIZE+1).
REQ-021 full SHALL assert when the pointers differ only in the MSB; empty SHALL assert when the pointers are equal; both SHALL derive from registered state only.
REQ-022 A write SHALL be accepted when winc=1 and (full=0 or rinc=1); an accepted write stores wdata at the write pointer and increments it.
REQ-023 A read SHALL be accepted when rinc=1 and empty=0; an accepted read increments the read pointer.
REQ-024 rdata SHALL combinationally show the entry at the read pointer when empty=0, and SHALL drive 0 when empty=1.
REQ-025 Written data SHALL become visible on rdata the cycle after the write edge; there is no same-cycle write-to-read bypass.
REQ-026 When full, rinc=1 and winc=1 in the same cycle, both SHALL be accepted and count SHALL stay DEPTH.
REQ-027 When empty, rinc=1 and winc=1 in the same cycle, the read SHALL be rejected (underflow set), the write accepted, and count SHALL become 1.
REQ-028 count SHALL update registered: +1 on write only, -1 on read only, and unchanged on both or neither.
REQ-029 overflow SHALL set on the edge where winc=1 and the write is rejected; underflow SHALL set where rinc=1 and empty=1; both SHALL hold until clr_err, rst or flush.
REQ-030 If clr_err and a new error event occur in the same cycle, the flag SHALL end set.
REQ-031 flush=1 SHALL on that edge zero both pointers, count, overflow and underflow, and SHALL take priority over winc and rinc (data presented that cycle is dropped).
REQ-032 Memory contents SHALL NOT be reset or cleared; only pointers, count and flags are.
REQ-033 almost_full and almost_empty SHALL be registered-state compares of count against the parameters, valid on the same cycle as count.

Reset
REQ-034 While rst=1 at a clock edge: pointers=0, count=0, overflow=0, underflow=0; winc, rinc and flush SHALL be ignored.
REQ-035 After reset: empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0), rdata=0.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries at that edge with no partial write.

Verification
REQ-037 Defaults: reset, write 0x01..0x10 (16 writes) -> full=1, count=16, almost_full=1 from count 14; read 16 -> data 0x01..0x10 in order, empty=1.
REQ-038 Full plus winc only -> overflow=1, count stays 16, contents unchanged; clr_err -> overflow=0 next cycle.
REQ-039 Full with winc=rinc=1, wdata=0xAA -> head popped, count=16; after 15 more reads, rdata=0xAA.
REQ-040 Empty with winc=rinc=1, wdata=0x55 -> underflow=1, count=1, rdata=0x55 the next cycle.
REQ-041 Load 40 entries with interleaved reads (pointer wrap twice) -> output order matches a reference queue, count tracks exactly.
REQ-042 Count=9 with flush=1 and winc=1 -> count=0, empty=1, flags cleared, written word absent; rst mid-stream -> same state as REQ-035.

Source files
------------

// File: rtl/param_fifo_if.sv
// param_fifo_if: write/read handshake, data and status bundle between a FIFO and its user
interface param_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic             flush;
  logic             clr_err;
  logic [DSIZE-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;
  modport master (
    output wdata, winc, rinc, flush, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wdata, winc, rinc, flush, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO with first-word fall-through read, level flags and sticky errors
module param_fifo #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic         clk,
  input logic         rst,
  param_fifo_if.slave bus
);
  localparam int             DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE    = (ASIZE+1)'(AE_LEVEL);
  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr, cnt;
  logic             ovf, udf, full, empty, do_wr, do_rd;
  assign full  = (wptr ^ rptr) == {1'b1, {ASIZE{1'b0}}};
  assign empty = wptr == rptr;
  // a pop in the same cycle frees the slot, so a full FIFO still takes the write
  assign do_wr = bus.winc && (!full || bus.rinc);
  assign do_rd = bus.rinc && !empty;
  always_ff @(posedge clk)
    if (!rst && !bus.flush && do_wr) mem[wptr[ASIZE-1:0]] <= bus.wdata;
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      cnt <= (do_wr && !do_rd) ? cnt + 1'b1 : (do_rd && !do_wr) ? cnt - 1'b1 : cnt;
      ovf <= (ovf && !bus.clr_err) || (bus.winc && !do_wr);
      udf <= (udf && !bus.clr_err) || (bus.rinc && empty);
    end
  assign bus.rdata        = empty ? '0 : mem[rptr[ASIZE-1:0]];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = cnt;
  assign bus.almost_full  = cnt >= AF;
  assign bus.almost_empty = cnt <= AE;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: randomized and directed checks of param_fifo against a queue-based reference model
module tb_param_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit m_ovf, m_udf;
  param_fifo_if #(.DSIZE(8), .ASIZE(4)) bus ();
  param_fifo dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input bit r_st, input bit w, input logic [7:0] d, input bit r,
                      input bit f = 1'b0, input bit c = 1'b0);
    bit wa, ra;
    rst = r_st; bus.winc = w; bus.wdata = d; bus.rinc = r; bus.flush = f; bus.clr_err = c;
    if (r_st || f) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      ra = r && q.size() > 0;
      wa = w && (q.size() < DEPTH || r);
      m_ovf = (m_ovf && !c) || (w && !wa);
      m_udf = (m_udf && !c) || (r && q.size() == 0);
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
    end
    @(posedge clk); #1;
    rst = 0; bus.winc = 0; bus.rinc = 0; bus.flush = 0; bus.clr_err = 0;
  endtask

  task automatic test_reset;
    step(1, 1, 8'h77, 1, 1);
    step(1, 1, 8'h78, 0);
    checks++;
    if (bus.empty !== 1 || bus.full !== 0 || bus.almost_empty !== 1 || bus.almost_full !== 0 ||
        bus.rdata !== 8'h00 || bus.count !== 5'd0 || bus.overflow !== 0 || bus.underflow !== 0) begin
      errors++;
      $display("FAIL reset: e=%b f=%b ae=%b af=%b rdata=%h cnt=%0d ovf=%b udf=%b required 1 0 1 0 00 0 0 0",
               bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.rdata, bus.count, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 8'(i), 0);
      checks++;
      if (bus.count !== 5'(i) || bus.almost_full !== (i >= 14) || bus.full !== (i == 16) ||
          bus.almost_empty !== (i <= 2) || bus.empty !== 0) begin
        errors++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b f=%b ae=%b e=%b", i, bus.count, bus.almost_full,
                 bus.full, bus.almost_empty, bus.empty);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (bus.rdata !== 8'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: rdata=%h required %h", i, bus.rdata, 8'(i));
      end
      step(0, 0, 8'h00, 1);
    end
    checks++;
    if (bus.empty !== 1 || bus.count !== 5'd0 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL drained: e=%b cnt=%0d rdata=%h required 1 0 00", bus.empty, bus.count, bus.rdata);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), 0);
    step(0, 1, 8'hEE, 0);
    checks++;
    if (bus.overflow !== 1 || bus.count !== 5'd16 || bus.rdata !== q[0]) begin
      errors++;
      $display("FAIL overflow: ovf=%b cnt=%0d rdata=%h required 1 16 %h", bus.overflow, bus.count, bus.rdata, q[0]);
    end
    step(0, 0, 8'h00, 0, 0, 1);
    checks++;
    if (bus.overflow !== 0) begin
      errors++;
      $display("FAIL clr_err: ovf=%b required 0", bus.overflow);
    end
  endtask

  task automatic test_full_rw;
    logic [7:0] second;
    second = q[1];
    step(0, 1, 8'hAA, 1);
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1 || bus.rdata !== second || bus.overflow !== 0) begin
      errors++;
      $display("FAIL full_rw: cnt=%0d f=%b rdata=%h ovf=%b required 16 1 %h 0", bus.count, bus.full,
               bus.rdata, bus.overflow, second);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (bus.rdata !== q[0]) begin
        errors++;
        $display("FAIL full_rw_drain[%0d]: rdata=%h required %h", i, bus.rdata, q[0]);
      end
      step(0, 0, 8'h00, 1);
    end
    checks++;
    if (bus.rdata !== 8'hAA || bus.count !== 5'd1) begin
      errors++;
      $display("FAIL full_rw_tail: rdata=%h cnt=%0d required aa 1", bus.rdata, bus.count);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_empty_rw;
    step(0, 1, 8'h55, 1);
    checks++;
    if (bus.underflow !== 1 || bus.count !== 5'd1 || bus.rdata !== 8'h55) begin
      errors++;
      $display("FAIL empty_rw: udf=%b cnt=%0d rdata=%h required 1 1 55", bus.underflow, bus.count, bus.rdata);
    end
    step(0, 0, 8'h00, 1, 0, 1);
    checks++;
    if (bus.underflow !== 0 || bus.empty !== 1) begin
      errors++;
      $display("FAIL empty_rw_clr: udf=%b e=%b required 0 1", bus.underflow, bus.empty);
    end
    step(0, 0, 8'h00, 1, 0, 1);
    checks++;
    if (bus.underflow !== 1) begin
      errors++;
      $display("FAIL clr_vs_event: udf=%b required 1", bus.underflow);
    end
    step(0, 0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_random;
    int writes = 0;
    for (int i = 0; i < 300; i++) begin
      bit w, r, c;
      int lvl;
      lvl = q.size();
      w = ($urandom_range(0, 99) < (i < 150 ? 70 : 45));
      r = ($urandom_range(0, 99) < (i < 150 ? 40 : 60));
      c = ($urandom_range(0, 15) == 0);
      if (w && (lvl < DEPTH || r)) writes++;
      step(0, w, 8'($urandom), r, 0, c);
      checks++;
      if (bus.count !== 5'(q.size()) || bus.rdata !== (q.size() > 0 ? q[0] : 8'h00) ||
          bus.full !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0) ||
          bus.almost_full !== (q.size() >= 14) || bus.almost_empty !== (q.size() <= 2) ||
          bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
        errors++;
        $display("FAIL random[%0d]: cnt=%0d rdata=%h f=%b e=%b af=%b ae=%b ovf=%b udf=%b required cnt=%0d rdata=%h ovf=%b udf=%b",
                 i, bus.count, bus.rdata, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                 bus.overflow, bus.underflow, q.size(), (q.size() > 0 ? q[0] : 8'h00), m_ovf, m_udf);
      end
    end
    checks++;
    if (writes < 40) begin
      errors++;
      $display("FAIL random_writes: %0d accepted writes required >= 40", writes);
    end
  endtask

  task automatic test_flush;
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h40 + i), 0);
    checks++;
    if (bus.count !== 5'd9 || bus.underflow !== 1) begin
      errors++;
      $display("FAIL pre_flush: cnt=%0d udf=%b required 9 1", bus.count, bus.underflow);
    end
    step(0, 1, 8'hEE, 0, 1);
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1 || bus.underflow !== 0 || bus.overflow !== 0 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL flush: cnt=%0d e=%b udf=%b ovf=%b rdata=%h required 0 1 0 0 00", bus.count, bus.empty,
               bus.underflow, bus.overflow, bus.rdata);
    end
    step(0, 1, 8'h33, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.rdata !== 8'h33) begin
      errors++;
      $display("FAIL post_flush: cnt=%0d rdata=%h required 1 33", bus.count, bus.rdata);
    end
  endtask

  task automatic test_rst_mid;
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), i[0]);
    step(1, 1, 8'hCC, 1);
    checks++;
    if (bus.empty !== 1 || bus.full !== 0 || bus.almost_empty !== 1 || bus.almost_full !== 0 ||
        bus.rdata !== 8'h00 || bus.count !== 5'd0 || bus.overflow !== 0 || bus.underflow !== 0) begin
      errors++;
      $display("FAIL rst_mid: e=%b f=%b ae=%b af=%b rdata=%h cnt=%0d ovf=%b udf=%b required 1 0 1 0 00 0 0 0",
               bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.rdata, bus.count, bus.overflow, bus.underflow);
    end
    step(0, 1, 8'h5A, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.rdata !== 8'h5A) begin
      errors++;
      $display("FAIL rst_resume: cnt=%0d rdata=%h required 1 5a", bus.count, bus.rdata);
    end
  endtask

  initial begin
    rst = 1; bus.winc = 0; bus.rinc = 0; bus.flush = 0; bus.clr_err = 0; bus.wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_random();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
